// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan with frame-aligned double-buffered digit updates
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lz_blank_en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(DIGITS);
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx, idx_nx;
  logic [4*DIGITS-1:0] active, pending;
  logic                pend, tick, wrap, commit, blank;
  logic [DIGITS-1:0]   zero_up;
  logic [3:0]          dig;
  assign wr_ready = !pend;
  assign tick     = enable && cnt == CW'(DWELL - 1);
  assign wrap     = tick && idx == IW'(DIGITS - 1);
  assign commit   = pend && (wrap || !enable);
  // next digit index plus its value and leading-zero blank decision
  always_comb begin
    idx_nx = (!enable || wrap) ? '0 : tick ? idx + IW'(1) : idx;
    zero_up[DIGITS-1] = active[4*DIGITS-1 -: 4] == 4'h0;
    for (int i = DIGITS - 2; i >= 0; i--) zero_up[i] = zero_up[i+1] && active[4*i +: 4] == 4'h0;
    dig   = active[{idx_nx, 2'b00} +: 4];
    blank = lz_blank_en && idx_nx != '0 && zero_up[idx_nx];
  end
  // dwell prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= (!enable || tick) ? '0 : cnt + CW'(1);
      idx <= idx_nx;
    end
  end
  // posted-value capture and frame-boundary commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      pend    <= 1'b0;
    end else if (commit) begin
      active <= pending;
      pend   <= 1'b0;
    end else if (wr_valid && !pend) begin
      pending <= wr_data;
      pend    <= 1'b1;
    end
  end
  // registered anode/decoder outputs with a dead cycle on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      num        <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      an         <= (!enable || tick) ? '1 : ~(DIGITS'(1) << idx_nx);
      num        <= (!enable || tick || blank) ? 4'hF : dig;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, handshake, commit timing, blanking, disable and reset
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, lz_blank_en, wr_valid, wr_ready, frame_done;
  logic [15:0] wr_data;
  logic [3:0]  num, an;
  int          total = 0, passed = 0;
  seg_scan_ctrl #(.DIGITS(4), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank_en(lz_blank_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .num(num), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_frame(input logic [15:0] val, input logic lz, input int start);
    logic [3:0] e_an, e_num, d;
    int slot, ph;
    bit bl;
    lz_blank_en = lz;
    for (int c = start; c < 16; c++) begin
      cyc();
      slot  = c / 4;
      ph    = c % 4;
      d     = 4'((val >> (4 * slot)) & 16'hF);
      bl    = lz && slot > 0 && (val >> (4 * slot)) == 16'h0;
      e_an  = ph == 3 ? 4'hF : ~(4'b0001 << slot);
      e_num = (ph == 3 || bl) ? 4'hF : d;
      check($sformatf("an %h c%0d", val, c), 16'(an), 16'(e_an));
      check($sformatf("num %h c%0d", val, c), 16'(num), 16'(e_num));
      check($sformatf("fd %h c%0d", val, c), 16'(frame_done), 16'(c == 15));
    end
  endtask
  task automatic post(input logic [15:0] val);
    wr_valid = 1'b1;
    wr_data  = val;
    cyc();
    wr_valid = 1'b0;
    repeat (15) cyc();
  endtask
  initial begin
    rst_n = 1'b0; enable = 1'b1; lz_blank_en = 1'b0; wr_valid = 1'b0; wr_data = '0;
    @(negedge clk);
    check("rst an", 16'(an), 16'hF);
    check("rst num", 16'(num), 16'hF);
    check("rst fd", 16'(frame_done), 16'h0);
    check("rst ready", 16'(wr_ready), 16'h1);
    rst_n = 1'b1;
    run_frame(16'h0000, 1'b0, 0);
    repeat (5) cyc();
    wr_valid = 1'b1; wr_data = 16'h1234;
    cyc();
    wr_valid = 1'b0;
    check("hs ready low", 16'(wr_ready), 16'h0);
    check("hs an", 16'(an), 16'hD);
    check("hs num old", 16'(num), 16'h0);
    repeat (9) cyc();
    check("hs num before boundary", 16'(num), 16'h0);
    cyc();
    check("hs ready back", 16'(wr_ready), 16'h1);
    check("hs fd", 16'(frame_done), 16'h1);
    run_frame(16'h1234, 1'b0, 0);
    wr_valid = 1'b1; wr_data = 16'h1111;
    cyc();
    wr_data = 16'h2222;
    repeat (14) cyc();
    check("bp ready held", 16'(wr_ready), 16'h0);
    check("bp old frame", 16'(num), 16'h1);
    cyc();
    check("bp ready after commit", 16'(wr_ready), 16'h1);
    cyc();
    wr_valid = 1'b0;
    check("bp second captured", 16'(wr_ready), 16'h0);
    check("bp digit0", 16'(num), 16'h1);
    check("bp an0", 16'(an), 16'hE);
    run_frame(16'h1111, 1'b0, 1);
    run_frame(16'h2222, 1'b0, 0);
    repeat (15) cyc();
    wr_valid = 1'b1; wr_data = 16'h5678;
    cyc();
    wr_valid = 1'b0;
    check("sc ready", 16'(wr_ready), 16'h0);
    check("sc fd", 16'(frame_done), 16'h1);
    run_frame(16'h2222, 1'b0, 0);
    run_frame(16'h5678, 1'b0, 0);
    post(16'h0045);
    run_frame(16'h0045, 1'b1, 0);
    post(16'h0000);
    run_frame(16'h0000, 1'b1, 0);
    run_frame(16'h0000, 1'b0, 0);
    repeat (9) cyc();
    check("dis an digit2", 16'(an), 16'hB);
    wr_valid = 1'b1; wr_data = 16'h9876;
    cyc();
    wr_valid = 1'b0;
    enable = 1'b0;
    cyc();
    check("dis an", 16'(an), 16'hF);
    check("dis num", 16'(num), 16'hF);
    check("dis drain", 16'(wr_ready), 16'h1);
    cyc();
    check("dis fd", 16'(frame_done), 16'h0);
    enable = 1'b1;
    cyc();
    check("en an", 16'(an), 16'hE);
    check("en num", 16'(num), 16'h6);
    repeat (2) cyc();
    check("en still lit", 16'(an), 16'hE);
    cyc();
    check("en dwell dead", 16'(an), 16'hF);
    wr_valid = 1'b1; wr_data = 16'h1111;
    cyc();
    wr_valid = 1'b0;
    check("mr posted", 16'(wr_ready), 16'h0);
    check("mr lit", 16'(an), 16'hD);
    #2 rst_n = 1'b0;
    #1;
    check("mr an", 16'(an), 16'hF);
    check("mr num", 16'(num), 16'hF);
    check("mr ready", 16'(wr_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(16'h0000, 1'b0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display that shares one 4-bit digit decoder across all digits. It holds a double-buffered digit value, steps the anode select at a programmable dwell rate, and drives the shared decoder input. Blanking uses code 4'hF, which the decoder maps to all segments off. A valid/ready write port lets the datapath post new values; the controller commits them only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface

- DIGITS, 4: number of multiplexed digits (2..8).
- DWELL, 100000: clock cycles per digit slot, including one dead cycle (minimum 2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; 0 blanks the display and holds the scan at digit 0.
- lz_blank_en  in  1  leading-zero blanking enable.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept; equals !pend.
- wr_data  in  4*DIGITS  BCD digits; digit i is wr_data[4i+3:4i], and digit 0 is least significant.
- num  out  4  registered decoder input; 4'hF means blank.
- an  out  DIGITS  registered anode select, active-low one-hot; all ones means nothing lit.
- frame_done  out  1  registered one-cycle pulse, asserted once per completed frame.

## Operation

- **State:** `cnt` (prescaler, clog2(DWELL) bits), `idx` (digit index), `active` (displayed value), `pending` (posted value), `pend` (pending-valid flag).
- **Reset (async):** cnt=0, idx=0, active=0, pending=0, pend=0, an=all ones, num=4'hF, frame_done=0. wr_ready=1 out of reset.
- **Write capture:** when wr_valid && wr_ready, the controller latches pending<=wr_data and sets pend<=1. While pend=1, wr_ready=0 and wr_data is ignored.
- **Prescaler:** when enable=1, cnt increments each cycle. `tick` = enable && cnt==DWELL-1; on tick, cnt<=0.
- **Digit step on tick:** idx<=idx+1, wrapping from DIGITS-1 to 0.
- **Frame boundary:** a tick with idx==DIGITS-1.
  - At this edge, if pend=1: active<=pending and pend<=0.
  - frame_done<=1 for one cycle.
- **Same-cycle capture and commit:** a capture in the boundary cycle does not commit at that boundary. The boundary uses the pre-edge pend; the new value commits at the next boundary.
- **enable=0:**
  - cnt<=0, idx<=0, an<=all ones, num<=4'hF, frame_done<=0.
  - Any posted value commits on every edge (active<=pending, pend<=0), so writes drain while the display is disabled.
- **Output registers:** each edge with enable=1, the controller computes an/num from the next idx value.
  - On a tick edge: an<=all ones, num<=4'hF (dead cycle for anti-ghosting).
  - Otherwise: an<=~(1<<idx), num<=digit(active, idx), or 4'hF if that digit is blanked.
- **Leading-zero blanking:** with lz_blank_en=1, digit i (i>0) is blanked when digits DIGITS-1..i of `active` are all zero. Digit 0 is never blanked.
- **Non-BCD digits (A..F):** passed through unmodified; the decoder shows them blank.

## Timing

- First edge after reset release with enable=1: an=~1 (digit 0 lit), num=digit0.
- Per slot: DWELL-1 lit cycles plus 1 dead cycle. Frame period = DIGITS*DWELL cycles.
- Write-to-display latency: from the capture edge to the first following boundary edge. The new digit 0 appears one cycle after that edge, at the end of the dead cycle.
- frame_done is high during the dead cycle that follows the wrap.
- wr_ready falls the cycle after capture and rises the cycle after commit.
- Reset asserted mid-frame forces all reset values immediately, without waiting for a clock edge. A posted but uncommitted value is lost.
- enable falling: blank on the next edge. enable rising: digit 0 is lit on the next edge, and the full DWELL count restarts.

## Test plan

1. **Reset and scan** (DIGITS=4, DWELL=4, enable=1, active=0):
   - an sequence: 1110 ×3, 1111, 1101 ×3, 1111, 1011 ×3, 1111, 0111 ×3, 1111.
   - frame_done pulses once every 16 cycles, coincident with the fourth 1111 cycle.
2. **Write handshake:**
   - Post wr_data=16'h1234 mid-frame: wr_ready drops the next cycle.
   - num stays 0 until the boundary; the next frame shows 4,3,2,1 on digits 0..3; wr_ready returns to 1.
3. **Backpressure:**
   - Post 16'h1111, then hold wr_valid with 16'h2222 before the boundary: the second value is accepted only after the commit.
   - Display shows 1111 for one frame, then 2222.
4. **Same-cycle capture at boundary:**
   - Capture 16'h5678 exactly in the wrap-tick cycle: it is not shown in the next frame, and it commits at the following boundary.
5. **Leading-zero blanking:**
   - active=16'h0045 with lz_blank_en=1: digits 3 and 2 drive num=4'hF, digits 1 and 0 drive 4 and 5.
   - active=16'h0000: only digit 0 drives 0. With lz_blank_en=0, every digit drives 0.
6. **Disable and mid-frame reset:**
   - enable=0 during digit 2: an=1111 and num=F on the next edge, and a posted value commits immediately.
   - Re-enable: digit 0 is lit on the next edge.
   - Drop rst_n mid-slot: an=1111, num=F, wr_ready=1 without a clock edge.
